// File: rtl/pulse_sched_ctrl.sv
// Random-gap pulse sequencer: each pulse is preceded by a one-cycle DRAW of a
// bounded random gap; runs a programmed burst or continuously until stopped.
module pulse_sched_ctrl #(
  parameter int RND_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [RND_W-1:0] cfg_min_gap,
  input  logic [RND_W-1:0] cfg_mask,
  input  logic [3:0]       cfg_width,
  input  logic [7:0]       cfg_burst,
  input  logic [RND_W-1:0] rnd,
  output logic             rnd_step,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_count
);

  typedef enum logic [2:0] {IDLE, DRAW, GAP, PULSE, DONE} state_t;

  localparam logic [RND_W:0]   GAP_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state;
  logic [RND_W-1:0] min_q;
  logic [RND_W-1:0] mask_q;
  logic [3:0]       width_q;
  logic [7:0]       burst_q;
  logic [7:0]       burst_left;
  logic [RND_W:0]   gap_cnt;
  logic [3:0]       wid_cnt;
  logic [RND_W:0]   gap;
  logic [3:0]       wid_eff;

  // One extra bit so min + masked rnd can never wrap.
  always_comb begin
    gap     = {1'b0, min_q} + {1'b0, rnd & mask_q};
    wid_eff = (width_q == 4'd0) ? 4'd1 : width_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      min_q       <= '0;
      mask_q      <= '0;
      width_q     <= '0;
      burst_q     <= '0;
      burst_left  <= '0;
      gap_cnt     <= '0;
      wid_cnt     <= '0;
      rnd_step    <= 1'b0;
      pulse       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulse_count <= '0;
    end else begin
      rnd_step <= 1'b0;
      done     <= 1'b0;
      // Abort wins over every transition, including the counting edge of a pulse.
      if (state != IDLE && stop) begin
        state <= IDLE;
        pulse <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              min_q      <= cfg_min_gap;
              mask_q     <= cfg_mask;
              width_q    <= cfg_width;
              burst_q    <= cfg_burst;
              burst_left <= cfg_burst;
              state      <= DRAW;
              busy       <= 1'b1;
              rnd_step   <= 1'b1;
            end
          end
          DRAW: begin
            if (gap == '0) begin
              state   <= PULSE;
              pulse   <= 1'b1;
              wid_cnt <= wid_eff;
            end else begin
              state   <= GAP;
              gap_cnt <= gap;
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt - GAP_ONE;
            if (gap_cnt == GAP_ONE) begin
              state   <= PULSE;
              pulse   <= 1'b1;
              wid_cnt <= wid_eff;
            end
          end
          PULSE: begin
            wid_cnt <= wid_cnt - 4'd1;
            if (wid_cnt == 4'd1) begin
              pulse       <= 1'b0;
              pulse_count <= pulse_count + CNT_ONE;
              if (burst_q != 8'd0) begin
                burst_left <= burst_left - 8'd1;
              end
              if (burst_q != 8'd0 && burst_left == 8'd1) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state    <= DRAW;
                rnd_step <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            pulse <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_sched_ctrl.sv
// Bench for pulse_sched_ctrl: each run is planned as a cycle timeline from the
// draw/gap/width arithmetic and compared cycle by cycle against the outputs.
module tb_pulse_sched_ctrl;

  localparam int CW   = 8;
  localparam int MAXC = 4096;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [7:0]      cfg_min_gap = '0;
  logic [7:0]      cfg_mask = '0;
  logic [3:0]      cfg_width = '0;
  logic [7:0]      cfg_burst = '0;
  logic [7:0]      rnd;
  logic            rnd_step;
  logic            pulse;
  logic            busy;
  logic            done;
  logic [CW-1:0]   pulse_count;

  pulse_sched_ctrl #(.RND_W(8), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_min_gap(cfg_min_gap), .cfg_mask(cfg_mask), .cfg_width(cfg_width),
    .cfg_burst(cfg_burst), .rnd(rnd), .rnd_step(rnd_step), .pulse(pulse),
    .busy(busy), .done(done), .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int base_cnt = 0;

  // External random source: advances once for every cycle rnd_step was high.
  logic [7:0] lfsr = 8'h5A;
  bit         step_pending = 1'b0;
  assign rnd = lfsr;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(negedge clk) if (rnd_step) step_pending = 1'b1;
  always @(posedge clk) begin
    #1;
    if (step_pending) begin
      lfsr = lfsr_next(lfsr);
      step_pending = 1'b0;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs for cycle r after the edge that accepts start.
  bit e_pulse [MAXC];
  bit e_busy  [MAXC];
  bit e_done  [MAXC];
  bit e_step  [MAXC];
  int e_cnt   [MAXC];

  task automatic build_model(input int mn, input int mk, input int wd, input int bst,
                             input int stp, input logic [7:0] seed, output int n);
    int w, d, i, g, end_at;
    logic [7:0] r;
    w = (wd == 0) ? 1 : wd;
    d = 0; i = 0; end_at = -1; r = seed;
    for (int t = 0; t < MAXC; t++) begin
      e_pulse[t] = 0; e_busy[t] = 0; e_done[t] = 0; e_step[t] = 0; e_cnt[t] = 0;
    end
    while (d < MAXC - 600) begin
      e_step[d] = 1;
      g = mn + (int'(r) & mk);
      r = lfsr_next(r);
      for (int t = d; t <= d + g + w; t++) e_busy[t] = 1;
      for (int t = d + 1 + g; t <= d + g + w; t++) e_pulse[t] = 1;
      d = d + 1 + g + w;
      i++;
      e_cnt[d] += 1;
      if (bst != 0 && i == bst) begin
        e_busy[d] = 1;
        e_done[d] = 1;
        end_at = d;
        break;
      end
      if (stp >= 0 && d > stp) break;
    end
    for (int t = 1; t < MAXC; t++) e_cnt[t] += e_cnt[t-1];
    if (stp >= 0 && (end_at < 0 || stp < end_at)) begin
      for (int t = stp + 1; t < MAXC; t++) begin
        e_pulse[t] = 0; e_busy[t] = 0; e_done[t] = 0; e_step[t] = 0;
        e_cnt[t] = e_cnt[stp];
      end
      n = stp + 1;
    end else begin
      n = end_at + 1;
    end
  endtask

  // Called at a negedge while idle; returns at the first idle negedge afterwards.
  task automatic run(input int mn, input int mk, input int wd, input int bst,
                     input int stp, input bit noise);
    int n;
    chk("idle_busy", busy, 0);
    chk("idle_pulse", pulse, 0);
    build_model(mn, mk, wd, bst, stp, lfsr, n);
    cfg_min_gap = mn[7:0];
    cfg_mask    = mk[7:0];
    cfg_width   = wd[3:0];
    cfg_burst   = bst[7:0];
    start = 1'b1;
    stop  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < n; r++) begin
      chk("pulse", pulse, e_pulse[r]);
      chk("busy", busy, e_busy[r]);
      chk("done", done, e_done[r]);
      chk("rnd_step", rnd_step, e_step[r]);
      chk("pulse_count", pulse_count, (base_cnt + e_cnt[r]) % (1 << CW));
      stop  = (r == stp);
      start = noise && e_busy[r] && ($urandom_range(0, 3) == 0);
      if (noise && e_busy[r]) begin
        cfg_min_gap = 8'($urandom);
        cfg_mask    = 8'($urandom);
        cfg_width   = 4'($urandom);
        cfg_burst   = 8'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
    base_cnt = base_cnt + e_cnt[n-1];
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int mn, mk, wd, bst, stp, n;

    // Reset held with start asserted
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pulse", pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", rnd_step, 0);
    chk("rst_count", pulse_count, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run(3, 0, 2, 3, -1, 1'b0);          // fixed burst
    run(0, 8'h0F, 3, 6, -1, 1'b0);      // random gap
    run(0, 0, 3, 2, -1, 1'b1);          // zero gap, noisy inputs
    run(0, 0, 0, 0, 599, 1'b0);         // continuous, count wraps
    run(1, 0, 0, 0, 31, 1'b0);          // continuous, stop mid-gap
    run(3, 0, 8, 0, 7, 1'b0);           // stop on 4th high cycle
    run(3, 0, 2, 3, -1, 1'b1);          // restart right after stop, noisy inputs

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_step", rnd_step, 0);
    @(negedge clk);
    chk("startstop_busy2", busy, 0);

    // Widest gap
    lfsr = 8'hFF;
    run(255, 255, 1, 1, -1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      mn  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0: mk = 0;
        1: mk = 3;
        2: mk = 15;
        default: mk = int'($urandom_range(0, 255));
      endcase
      wd  = int'($urandom_range(0, 15));
      bst = int'($urandom_range(0, 5));
      if (bst == 0) stp = int'($urandom_range(0, 150));
      else stp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 100)) : -1;
      run(mn, mk, wd, bst, stp, 1'b1);
    end

    // Reset in the middle of a pulse
    build_model(2, 0, 6, 1, -1, lfsr, n);
    cfg_min_gap = 8'd2;
    cfg_mask    = 8'd0;
    cfg_width   = 4'd6;
    cfg_burst   = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_pulse", pulse, e_pulse[5]);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_pulse", pulse, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", pulse_count, 0);
    rst_n = 1'b1;
    base_cnt = 0;
    @(negedge clk);
    run(1, 0, 1, 2, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
